// File: rtl/cpu_sequencer_if.sv
// Control bundle between the CPU sequencer and its datapath.
// The master side is the sequencer; the slave side is the datapath or the bench.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             resume;
    logic             mem_rd;
    logic             mem_wr;
    logic             load_ir;
    logic             load_ac;
    logic             inc_pc;
    logic             load_pc;
    logic             halt;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready, resume,
        output mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, state, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready, resume,
        input  mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, state, instr_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Instruction sequencer for a small accumulator CPU: fetch/execute FSM with memory
// stalls, halt/resume and a wrapping retired-instruction counter.
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_,
    cpu_sequencer_if.master   bus
);
    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             alu_op_s;
    logic             is_skz_s, is_sto_s, is_jmp_s;
    logic             mem_rd_s, mem_wr_s, load_ir_s, load_ac_s;
    logic             inc_pc_s, load_pc_s, halt_s;

    // ADD, AND, XOR and LDA are contiguous opcodes 2..5
    assign alu_op_s = (bus.opcode >= OP_ADD) && (bus.opcode <= OP_LDA);
    assign is_skz_s = (bus.opcode == OP_SKZ);
    assign is_sto_s = (bus.opcode == OP_STO);
    assign is_jmp_s = (bus.opcode == OP_JMP);

    // State and retire counter; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_INST_ADDR;
            count_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state, counter update and strobe decode from state and opcode
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mem_rd_s  = 1'b0;
        mem_wr_s  = 1'b0;
        load_ir_s = 1'b0;
        load_ac_s = 1'b0;
        inc_pc_s  = 1'b0;
        load_pc_s = 1'b0;
        halt_s    = 1'b0;
        case (state_q)
            S_INST_ADDR: begin
                state_d = S_INST_FETCH;
            end
            S_INST_FETCH: begin
                mem_rd_s = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_INST_LOAD;
                end else begin
                    state_d = S_INST_FETCH;
                end
            end
            S_INST_LOAD: begin
                mem_rd_s  = 1'b1;
                load_ir_s = 1'b1;
                state_d   = S_IDLE;
            end
            S_IDLE: begin
                mem_rd_s  = 1'b1;
                load_ir_s = 1'b1;
                state_d   = S_OP_ADDR;
            end
            S_OP_ADDR: begin
                inc_pc_s = 1'b1;
                if (bus.opcode == OP_HLT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_OP_FETCH;
                end
            end
            S_OP_FETCH: begin
                mem_rd_s = alu_op_s;
                // Only an actual operand read waits for memory
                if (alu_op_s && !bus.mem_ready) begin
                    state_d = S_OP_FETCH;
                end else begin
                    state_d = S_ALU_OP;
                end
            end
            S_ALU_OP: begin
                mem_rd_s  = alu_op_s;
                load_ac_s = alu_op_s;
                inc_pc_s  = is_skz_s && bus.zero;
                load_pc_s = is_jmp_s;
                state_d   = S_STORE;
            end
            S_STORE: begin
                mem_rd_s  = alu_op_s;
                load_ac_s = alu_op_s;
                inc_pc_s  = is_jmp_s;
                load_pc_s = is_jmp_s;
                mem_wr_s  = is_sto_s;
                state_d   = S_INST_ADDR;
                count_d   = count_q + CNT_W'(1);
            end
            S_HALTED: begin
                halt_s = 1'b1;
                if (bus.resume) begin
                    state_d = S_INST_ADDR;
                end else begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                state_d = S_INST_ADDR;
            end
        endcase
    end

    assign bus.mem_rd      = mem_rd_s;
    assign bus.mem_wr      = mem_wr_s;
    assign bus.load_ir     = load_ir_s;
    assign bus.load_ac     = load_ac_s;
    assign bus.inc_pc      = inc_pc_s;
    assign bus.load_pc     = load_pc_s;
    assign bus.halt        = halt_s;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer: each instruction is expanded into an
// expected per-cycle state list with matching mem_ready/resume drive, then replayed.
module tb_cpu_sequencer;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_;
    int   total;
    int   bad;
    logic [CNT_W-1:0] exp_cnt;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       res;
    } step_t;

    cpu_sequencer_if #(.CNT_W(CNT_W)) bus ();

    cpu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe vector {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt} from the decode table
    function automatic logic [6:0] exp_strobes(input logic [3:0] st, input logic [2:0] op, input logic z);
        logic alu;
        logic [6:0] v;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        v = 7'd0;
        case (st)
            4'd1: v[6] = 1'b1;
            4'd2, 4'd3: begin v[6] = 1'b1; v[4] = 1'b1; end
            4'd4: v[2] = 1'b1;
            4'd5: v[6] = alu;
            4'd6: begin
                v[6] = alu; v[3] = alu;
                v[2] = (op == 3'd1) && z;
                v[1] = (op == 3'd7);
            end
            4'd7: begin
                v[6] = alu; v[3] = alu;
                v[2] = (op == 3'd7); v[1] = (op == 3'd7);
                v[5] = (op == 3'd6);
            end
            4'd8: v[0] = 1'b1;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    function automatic logic [6:0] dut_strobes();
        return {bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_ac, bus.inc_pc, bus.load_pc, bus.halt};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one instruction; abort_st (4'hF = never) pulses reset while in that state
    task automatic run_instr(input logic [2:0] op, input logic z, input int s1, input int s2,
                             input int hold, input logic [3:0] abort_st);
        step_t q[$];
        logic  alu;
        alu = (op >= 3'd2) && (op <= 3'd5);
        q.push_back('{4'd0, rbit(), rbit()});
        for (int i = 0; i < s1; i++) q.push_back('{4'd1, 1'b0, rbit()});
        q.push_back('{4'd1, 1'b1, rbit()});
        q.push_back('{4'd2, rbit(), rbit()});
        q.push_back('{4'd3, rbit(), rbit()});
        q.push_back('{4'd4, rbit(), rbit()});
        if (op == 3'd0) begin
            for (int i = 0; i < hold; i++) q.push_back('{4'd8, rbit(), 1'b0});
            q.push_back('{4'd8, rbit(), 1'b1});
        end else begin
            if (alu) begin
                for (int i = 0; i < s2; i++) q.push_back('{4'd5, 1'b0, rbit()});
                q.push_back('{4'd5, 1'b1, rbit()});
            end else begin
                q.push_back('{4'd5, rbit(), rbit()});
            end
            q.push_back('{4'd6, rbit(), rbit()});
            q.push_back('{4'd7, rbit(), rbit()});
        end
        bus.opcode = op;
        bus.zero   = z;
        foreach (q[k]) begin
            bus.mem_ready = q[k].rdy;
            bus.resume    = q[k].res;
            #1;
            check_eq("state", 32'(bus.state), 32'(q[k].st));
            check_eq("strobes", 32'(dut_strobes()), 32'(exp_strobes(q[k].st, op, z)));
            check_eq("count", 32'(bus.instr_count), 32'(exp_cnt));
            check_eq("rd_wr_excl", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
            if (q[k].st == abort_st) begin
                #1 rst_ = 1'b0;
                #1;
                exp_cnt = '0;
                check_eq("rst_state", 32'(bus.state), 32'd0);
                check_eq("rst_strobes", 32'(dut_strobes()), 32'd0);
                check_eq("rst_count", 32'(bus.instr_count), 32'(exp_cnt));
                @(negedge clk);
                rst_ = 1'b1;
                return;
            end
            @(posedge clk);
            if (q[k].st == 4'd7) exp_cnt = exp_cnt + 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_cnt = '0;
        rst_ = 1'b0;
        bus.opcode = 3'd2;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        bus.resume = 1'b1;
        #1;
        check_eq("reset_state", 32'(bus.state), 32'd0);
        check_eq("reset_strobes", 32'(dut_strobes()), 32'd0);
        check_eq("reset_count", 32'(bus.instr_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;

        run_instr(3'd2, 1'b0, 0, 0, 0, 4'hF);   // ADD
        run_instr(3'd1, 1'b1, 0, 0, 0, 4'hF);   // SKZ, zero set
        run_instr(3'd1, 1'b0, 0, 0, 0, 4'hF);   // SKZ, zero clear
        run_instr(3'd6, 1'b0, 1, 0, 0, 4'hF);   // STO
        run_instr(3'd7, 1'b1, 0, 0, 0, 4'hF);   // JMP
        run_instr(3'd5, 1'b0, 3, 2, 0, 4'hF);   // LDA with both stalls
        run_instr(3'd0, 1'b0, 0, 0, 5, 4'hF);   // HLT held 5 clocks
        for (int n = 0; n < 40; n++) begin
            run_instr(3'($urandom_range(0, 7)), rbit(), $urandom_range(0, 3),
                      $urandom_range(0, 2), $urandom_range(0, 4), 4'hF);
        end
        for (int n = 0; n < 17; n++) run_instr(3'd4, 1'b0, 0, 0, 0, 4'hF);
        run_instr(3'd5, 1'b0, 0, 2, 0, 4'd5);   // reset during OP_FETCH stall
        run_instr(3'd2, 1'b0, 0, 0, 0, 4'hF);
        run_instr(3'd0, 1'b0, 0, 0, 3, 4'd8);   // reset while halted
        run_instr(3'd3, 1'b1, 1, 1, 0, 4'hF);
        #1;
        check_eq("final_state", 32'(bus.state), 32'd0);
        check_eq("final_count", 32'(bus.instr_count), 32'(exp_cnt));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
